// File: rtl/mst_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// mst_cmd_arbiter
//   Arbitrates a read client and a write client onto a single bus-master
//   command port. One command is in flight at a time; ties between clients
//   are resolved round-robin (read wins the first tie after reset).
//   Every command is a burst of XFER_LEN bytes.
//
// Optional feature (macro MST_CMD_TIMEOUT_EN):
//   When defined, a watchdog aborts a command that spends TIMEOUT_CYCLES
//   cycles in CMD/WAIT_CMPLT. The abort sets err_sticky and pulses the
//   client's done, but does not bump its counter. When undefined, no
//   watchdog exists and the FSM waits indefinitely.
//
// Ports:
//   Clk, ResetL            clock, synchronous active-low reset
//   rd_req/rd_addr         read client request and byte address
//   rd_gnt/rd_done         read client grant and one-cycle completion pulse
//   wr_req/wr_addr         write client request and byte address
//   wr_gnt/wr_done         write client grant and one-cycle completion pulse
//   ip2bus_mstrd_req       master read command strobe
//   ip2bus_mstwr_req       master write command strobe
//   ip2bus_mst_addr        command address (latched at grant)
//   ip2bus_mst_length      command length, constant XFER_LEN
//   ip2bus_mst_type        command type, constant 1 (burst)
//   bus2ip_mst_cmdack      master accepted the command
//   bus2ip_mst_cmplt       master completed the command
//   bus2ip_mst_error       error qualifier sampled with cmplt
//   err_clr                clears err_sticky (a simultaneous set wins)
//   busy                   high whenever the FSM is not idle
//   err_sticky             latched error flag
//   rd_count/wr_count      completed-command counters, wrap at 16 bits
// ---------------------------------------------------------------------------
module mst_cmd_arbiter #(
    parameter int unsigned XFER_LEN       = 240,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        Clk,
    input  logic        ResetL,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_gnt,
    output logic        rd_done,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    output logic        wr_gnt,
    output logic        wr_done,
    output logic        ip2bus_mstrd_req,
    output logic        ip2bus_mstwr_req,
    output logic [31:0] ip2bus_mst_addr,
    output logic [19:0] ip2bus_mst_length,
    output logic        ip2bus_mst_type,
    input  logic        bus2ip_mst_cmdack,
    input  logic        bus2ip_mst_cmplt,
    input  logic        bus2ip_mst_error,
    input  logic        err_clr,
    output logic        busy,
    output logic        err_sticky,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT_CMPLT,
        DONE
    } state_t;

    state_t      r_state;
    logic        r_last_wr;   // 1: last grant went to the write client
    logic        r_rd_gnt;
    logic        r_wr_gnt;
    logic        r_mstrd_req;
    logic        r_mstwr_req;
    logic [31:0] r_addr;
    logic        r_rd_done;
    logic        r_wr_done;
    logic        r_err;
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;

    logic        w_pick_rd;
    logic        w_cmplt_ok;
    logic        w_finish;
    logic        w_err_set;

    // Read wins when alone, or on a tie when write was granted last.
    assign w_pick_rd  = rd_req && (!wr_req || r_last_wr);

    // Normal completion: cmplt in WAIT_CMPLT, or cmdack+cmplt together in CMD.
    assign w_cmplt_ok = bus2ip_mst_cmplt &&
                        ((r_state == CMD && bus2ip_mst_cmdack) || r_state == WAIT_CMPLT);

`ifdef MST_CMD_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] r_to_cnt;
    logic          w_watch;
    logic          w_timeout;

    assign w_watch   = (r_state == CMD) || (r_state == WAIT_CMPLT);
    // Counter starts at 0 on entry, so matching LIMIT-1 aborts after
    // exactly TIMEOUT_CYCLES cycles in the watched states.
    assign w_timeout = w_watch && !w_cmplt_ok && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_finish  = w_cmplt_ok || w_timeout;
    assign w_err_set = (w_cmplt_ok && bus2ip_mst_error) || w_timeout;

    always_ff @(posedge Clk) begin
        if (!ResetL || !w_watch || w_finish) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_finish  = w_cmplt_ok;
    assign w_err_set = w_cmplt_ok && bus2ip_mst_error;
`endif

    always_ff @(posedge Clk) begin
        if (!ResetL) begin
            r_state     <= IDLE;
            r_last_wr   <= 1'b1;
            r_rd_gnt    <= 1'b0;
            r_wr_gnt    <= 1'b0;
            r_mstrd_req <= 1'b0;
            r_mstwr_req <= 1'b0;
            r_addr      <= '0;
            r_rd_done   <= 1'b0;
            r_wr_done   <= 1'b0;
            r_err       <= 1'b0;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
        end else begin
            r_rd_done <= 1'b0;
            r_wr_done <= 1'b0;

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (rd_req || wr_req) begin
                        r_state     <= CMD;
                        r_last_wr   <= !w_pick_rd;
                        r_rd_gnt    <= w_pick_rd;
                        r_wr_gnt    <= !w_pick_rd;
                        r_mstrd_req <= w_pick_rd;
                        r_mstwr_req <= !w_pick_rd;
                        r_addr      <= w_pick_rd ? rd_addr : wr_addr;
                    end
                end
                CMD, WAIT_CMPLT: begin
                    if (w_finish) begin
                        r_state     <= DONE;
                        r_mstrd_req <= 1'b0;
                        r_mstwr_req <= 1'b0;
                        r_rd_done   <= r_rd_gnt;
                        r_wr_done   <= r_wr_gnt;
                        // An aborted command pulses done but is not counted.
                        if (w_cmplt_ok && r_rd_gnt) begin
                            r_rd_cnt <= r_rd_cnt + 16'd1;
                        end
                        if (w_cmplt_ok && r_wr_gnt) begin
                            r_wr_cnt <= r_wr_cnt + 16'd1;
                        end
                    end else if (r_state == CMD && bus2ip_mst_cmdack) begin
                        r_state     <= WAIT_CMPLT;
                        r_mstrd_req <= 1'b0;
                        r_mstwr_req <= 1'b0;
                    end
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_rd_gnt <= 1'b0;
                    r_wr_gnt <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rd_gnt            = r_rd_gnt;
    assign wr_gnt            = r_wr_gnt;
    assign rd_done           = r_rd_done;
    assign wr_done           = r_wr_done;
    assign ip2bus_mstrd_req  = r_mstrd_req;
    assign ip2bus_mstwr_req  = r_mstwr_req;
    assign ip2bus_mst_addr   = r_addr;
    assign ip2bus_mst_length = 20'(XFER_LEN);
    assign ip2bus_mst_type   = 1'b1;
    assign busy              = (r_state != IDLE);
    assign err_sticky        = r_err;
    assign rd_count          = r_rd_cnt;
    assign wr_count          = r_wr_cnt;

endmodule
